pss_peak_detector: RTL



---
 rtl/pss_pkg.sv | 28 ++
 rtl/pss_peak_detector_if.sv | 11 +
 rtl/moving_sum.sv | 43 ++++
 rtl/pss_peak_detector.sv | 108 ++++++++++
 4 files changed

// File: rtl/pss_pkg.sv
// Shared types and width helpers for the PSS peak-detection path.
// Derived widths are functions so that any instance parameterisation gets consistent sizes.
package pss_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } pss_state_e;

  localparam int unsigned IN_DW_DEF        = 24;
  localparam int unsigned POS_DW_DEF       = 16;
  localparam int unsigned AVG_LOG2_DEF     = 4;
  localparam int unsigned THRESH_SHIFT_DEF = 3;
  localparam int unsigned WINDOW_LEN_DEF   = 8;

  function automatic int unsigned sum_dw(input int unsigned in_dw, input int unsigned avg_log2);
    return in_dw + avg_log2;
  endfunction

  function automatic int unsigned thr_dw(input int unsigned in_dw, input int unsigned thresh_shift);
    return in_dw + thresh_shift;
  endfunction

  localparam int unsigned SUM_DW = sum_dw(IN_DW_DEF, AVG_LOG2_DEF);
  localparam int unsigned THR_DW = thr_dw(IN_DW_DEF, THRESH_SHIFT_DEF);

endpackage

// File: rtl/pss_peak_detector_if.sv
// Unidirectional sample stream with no backpressure.
// Handshake: there is no ready; one beat transfers on every clk_i rising edge where tvalid is high, and tdata is meaningful only on those cycles.
interface pss_peak_detector_if #(
    parameter int unsigned DW = 24
);
    logic [DW-1:0] tdata;
    logic          tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/moving_sum.sv
// Ring buffer of the last 2^LOG2 pushed samples with a running sum of its contents.
// filled_o looks ahead: it is high when the buffer is full, or becomes full with this cycle's push.
module moving_sum #(
    parameter int unsigned DW   = 24,
    parameter int unsigned LOG2 = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               push_i,
    input  logic [DW-1:0]      data_i,
    output logic [DW+LOG2-1:0] sum_o,
    output logic               filled_o
);
    localparam int unsigned   DEPTH = 1 << LOG2;
    localparam logic [LOG2:0] FULL  = (LOG2 + 1)'(DEPTH);
    localparam logic [LOG2:0] LAST  = FULL - 1'b1;

    logic [DW-1:0]   ring_q [DEPTH];
    logic [LOG2-1:0] wr_ptr_q;
    logic [LOG2:0]   fill_q;

    assign filled_o = (fill_q == FULL) || (push_i && (fill_q == LAST));

    // Unwritten slots hold zero, so subtracting the evicted entry is correct while filling.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_o    <= '0;
        end else if (push_i) begin
            sum_o            <= sum_o + (DW + LOG2)'(data_i) - (DW + LOG2)'(ring_q[wr_ptr_q]);
            ring_q[wr_ptr_q] <= data_i;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
            if (fill_q != FULL) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pss_peak_detector.sv
// Declares a PSS timing peak: a sample above a scaled moving-average floor, not exceeded within a hold window.
// Emits a one-cycle pulse with the peak position and magnitude; state_o exposes the FSM for observation.
module pss_peak_detector
  import pss_pkg::*;
#(
    parameter int unsigned IN_DW        = IN_DW_DEF,
    parameter int unsigned POS_DW       = POS_DW_DEF,
    parameter int unsigned AVG_LOG2     = AVG_LOG2_DEF,
    parameter int unsigned THRESH_SHIFT = THRESH_SHIFT_DEF,
    parameter int unsigned WINDOW_LEN   = WINDOW_LEN_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    pss_peak_detector_if.slave    s_axis_in,
    pss_peak_detector_if.master   m_axis_out,
    output logic [IN_DW-1:0]      peak_mag_o,
    output pss_state_e            state_o
);
    localparam int unsigned SUM_W  = sum_dw(IN_DW, AVG_LOG2);
    localparam int unsigned THR_W  = thr_dw(IN_DW, THRESH_SHIFT);
    localparam int unsigned HOLD_W = $clog2(WINDOW_LEN + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WINDOW_LEN - 1);

    pss_state_e          state_q;
    logic [POS_DW-1:0]   pos_q;
    logic [POS_DW-1:0]   cand_pos_q;
    logic [IN_DW-1:0]    cand_mag_q;
    logic [HOLD_W-1:0]   hold_q;

    logic [SUM_W-1:0]    noise_sum;
    logic                filled;
    logic [THR_W-1:0]    thresh;
    logic                over;
    logic                push;

    // Threshold is formed from the floor before the current sample enters the buffer.
    always_comb begin
        thresh = THR_W'(noise_sum >> AVG_LOG2) << THRESH_SHIFT;
        over   = THR_W'(s_axis_in.tdata) > thresh;
        push   = s_axis_in.tvalid &&
                 ((state_q == WARMUP) || ((state_q == SEARCH) && !over));
    end

    moving_sum #(
        .DW   (IN_DW),
        .LOG2 (AVG_LOG2)
    ) u_noise (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .data_i   (s_axis_in.tdata),
        .sum_o    (noise_sum),
        .filled_o (filled)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q           <= WARMUP;
            pos_q             <= '0;
            cand_pos_q        <= '0;
            cand_mag_q        <= '0;
            hold_q            <= '0;
            m_axis_out.tvalid <= 1'b0;
            m_axis_out.tdata  <= '0;
            peak_mag_o        <= '0;
        end else begin
            m_axis_out.tvalid <= 1'b0;
            if (s_axis_in.tvalid) begin
                pos_q <= pos_q + 1'b1;
                case (state_q)
                    WARMUP: begin
                        if (filled) begin
                            state_q <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (over) begin
                            cand_mag_q <= s_axis_in.tdata;
                            cand_pos_q <= pos_q;
                            hold_q     <= '0;
                            state_q    <= TRACK;
                        end
                    end
                    TRACK: begin
                        // Strictly larger only: an equal later sample leaves the earliest candidate.
                        if (s_axis_in.tdata > cand_mag_q) begin
                            cand_mag_q <= s_axis_in.tdata;
                            cand_pos_q <= pos_q;
                            hold_q     <= '0;
                        end else if (hold_q == HOLD_LAST) begin
                            m_axis_out.tvalid <= 1'b1;
                            m_axis_out.tdata  <= cand_pos_q;
                            peak_mag_o        <= cand_mag_q;
                            hold_q            <= '0;
                            state_q           <= SEARCH;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= WARMUP;
                endcase
            end
        end
    end

    assign state_o = state_q;

endmodule
